// File: rtl/jtag_mem_loader_if.sv
// ---------------------------------------------------------------------------
// jtag_mem_loader_if
//   Bundle of the word-serial J-port (host side) and the shared memory bus
//   (memory side) around jtag_mem_loader.
//
//   master : the test host plus memory environment. It drives the session
//            controls, load data, dump-ready and memory read data.
//   slave  : the loader. It drives the handshakes, memory address, data and
//            strobes, and the busy/done status.
//
//   Parameters: WIDTH (word width), AW (shared memory address width).
// ---------------------------------------------------------------------------
interface jtag_mem_loader_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 9
);
    // J-port
    logic             Jen;
    logic             Jmode;
    logic [WIDTH-1:0] Jin;
    logic             Jin_valid;
    logic             Jin_ready;
    logic [WIDTH-1:0] Jout;
    logic             Jout_valid;
    logic             Jout_ready;
    // memory bus
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             dmem_we;
    logic             imem_we;
    logic             dmem_re;
    logic             imem_re;
    logic [WIDTH-1:0] dmem_rdata;
    logic [WIDTH-1:0] imem_rdata;
    // status
    logic             busy;
    logic             done;

    modport slave (
        input  Jen, Jmode, Jin, Jin_valid, Jout_ready, dmem_rdata, imem_rdata,
        output Jin_ready, Jout, Jout_valid, mem_addr, mem_wdata,
               dmem_we, imem_we, dmem_re, imem_re, busy, done
    );

    modport master (
        output Jen, Jmode, Jin, Jin_valid, Jout_ready, dmem_rdata, imem_rdata,
        input  Jin_ready, Jout, Jout_valid, mem_addr, mem_wdata,
               dmem_we, imem_we, dmem_re, imem_re, busy, done
    );
endinterface

// File: rtl/jtag_mem_loader.sv
// ---------------------------------------------------------------------------
// jtag_mem_loader
//   Streams program images from the host into data memory then instruction
//   memory (load, Jmode=0), or streams both memories back out (dump,
//   Jmode=1). Within each region addresses run from DEPTH-1 down to 0.
//   busy holds the core in reset for the whole session; done pulses once
//   when a session completes normally. Dropping Jen mid-session aborts.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   bus   jtag_mem_loader_if.slave : J-port handshakes, memory bus, busy/done
//   chk   (only with LOADER_CHECKSUM_EN) rotate-and-add checksum of the
//         words moved during the current/last session
//
// Configuration macro: LOADER_CHECKSUM_EN enables the chk accumulator/port.
// ---------------------------------------------------------------------------
module jtag_mem_loader #(
    parameter int WIDTH      = 32,
    parameter int DMEM_DEPTH = 512,
    parameter int IMEM_DEPTH = 512,
    parameter int AW         = $clog2(DMEM_DEPTH > IMEM_DEPTH ? DMEM_DEPTH : IMEM_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    jtag_mem_loader_if.slave bus
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [WIDTH-1:0] chk
`endif
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LD_D, S_LD_I,
        S_RD_D, S_WT_D, S_OUT_D,
        S_RD_I, S_WT_I, S_OUT_I,
        S_FIN
    } state_t;

    localparam logic [AW-1:0] DTOP = AW'(DMEM_DEPTH - 1);
    localparam logic [AW-1:0] ITOP = AW'(IMEM_DEPTH - 1);

    state_t           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic             dwe_q, dwe_d;
    logic             iwe_q, iwe_d;
    logic [WIDTH-1:0] jout_q, jout_d;
    logic             done_q, done_d;

    logic in_ld, in_rd, in_out;
    logic jin_ready, jout_valid;
    logic load_acc, dump_hs;

`ifdef LOADER_CHECKSUM_EN
    logic [WIDTH-1:0] chk_q, chk_d;

    function automatic logic [WIDTH-1:0] chk_step(input logic [WIDTH-1:0] c,
                                                  input logic [WIDTH-1:0] w);
        return {c[WIDTH-2:0], c[WIDTH-1]} + w;
    endfunction
`endif

    // Handshake qualifiers depend only on registered state and Jen, never on
    // the opposite side's valid/ready. Gating with Jen keeps an aborting
    // cycle from accepting a word or issuing a read.
    assign in_ld      = (state_q == S_LD_D)  || (state_q == S_LD_I);
    assign in_rd      = (state_q == S_RD_D)  || (state_q == S_RD_I);
    assign in_out     = (state_q == S_OUT_D) || (state_q == S_OUT_I);
    assign jin_ready  = in_ld  && bus.Jen;
    assign jout_valid = in_out && bus.Jen;
    assign load_acc   = jin_ready  && bus.Jin_valid;
    assign dump_hs    = jout_valid && bus.Jout_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        dwe_d   = 1'b0;
        iwe_d   = 1'b0;
        jout_d  = jout_q;
        done_d  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        chk_d   = chk_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.Jen) begin
                    state_d = bus.Jmode ? S_RD_D : S_LD_D;
                    cnt_d   = DTOP;
`ifdef LOADER_CHECKSUM_EN
                    chk_d   = '0;
`endif
                end
            end

            S_LD_D, S_LD_I: begin
                if (!bus.Jen) begin
                    state_d = S_IDLE;
                end else if (load_acc) begin
                    // Write is registered: it hits memory the cycle after
                    // acceptance, so an abort right after still lands it.
                    addr_d  = cnt_q;
                    wdata_d = bus.Jin;
                    dwe_d   = (state_q == S_LD_D);
                    iwe_d   = (state_q == S_LD_I);
`ifdef LOADER_CHECKSUM_EN
                    chk_d   = chk_step(chk_q, bus.Jin);
`endif
                    if (cnt_q == '0) begin
                        if (state_q == S_LD_D) begin
                            state_d = S_LD_I;
                            cnt_d   = ITOP;
                        end else begin
                            state_d = S_FIN;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end

            S_RD_D: state_d = bus.Jen ? S_WT_D : S_IDLE;
            S_RD_I: state_d = bus.Jen ? S_WT_I : S_IDLE;

            S_WT_D, S_WT_I: begin
                if (!bus.Jen) begin
                    state_d = S_IDLE;
                end else begin
                    jout_d  = (state_q == S_WT_D) ? bus.dmem_rdata : bus.imem_rdata;
                    state_d = (state_q == S_WT_D) ? S_OUT_D : S_OUT_I;
                end
            end

            S_OUT_D, S_OUT_I: begin
                if (!bus.Jen) begin
                    state_d = S_IDLE;
                end else if (dump_hs) begin
`ifdef LOADER_CHECKSUM_EN
                    chk_d = chk_step(chk_q, jout_q);
`endif
                    if (cnt_q == '0) begin
                        if (state_q == S_OUT_D) begin
                            state_d = S_RD_I;
                            cnt_d   = ITOP;
                        end else begin
                            state_d = S_FIN;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d   = cnt_q - 1'b1;
                        state_d = (state_q == S_OUT_D) ? S_RD_D : S_RD_I;
                    end
                end
            end

            // Hold busy until the host releases Jen.
            S_FIN: if (!bus.Jen) state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            dwe_q   <= 1'b0;
            iwe_q   <= 1'b0;
            jout_q  <= '0;
            done_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            chk_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            dwe_q   <= dwe_d;
            iwe_q   <= iwe_d;
            jout_q  <= jout_d;
            done_q  <= done_d;
`ifdef LOADER_CHECKSUM_EN
            chk_q   <= chk_d;
`endif
        end
    end

    // Reads present the live counter; writes present the registered address.
    assign bus.mem_addr   = in_rd ? cnt_q : addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.dmem_we    = dwe_q;
    assign bus.imem_we    = iwe_q;
    assign bus.dmem_re    = (state_q == S_RD_D) && bus.Jen;
    assign bus.imem_re    = (state_q == S_RD_I) && bus.Jen;
    assign bus.Jin_ready  = jin_ready;
    assign bus.Jout       = jout_q;
    assign bus.Jout_valid = jout_valid;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = done_q;
`ifdef LOADER_CHECKSUM_EN
    assign chk            = chk_q;
`endif

endmodule
